// File: rtl/rca_seq_addsub.sv
// rca_seq_addsub: multi-cycle ripple-carry adder/subtractor.
// A WIDTH-bit operand pair is processed in CHUNK-bit slices, one slice per
// clock, with the inter-slice carry held in a register. Valid/ready
// handshakes on both sides. Reports carry, signed overflow, zero and
// negative flags.
// Optional build macro ALU_SAT_EN: saturate SUM to the signed limit when
// the completed operation overflows (flags cout/ovf stay unsaturated).
module rca_seq_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;
    logic               zero_q;
    logic               neg_q;
    logic               out_valid_q;

    logic [CHUNK-1:0]   a_sl;
    logic [CHUNK-1:0]   b_sl;
    logic [CHUNK-1:0]   s_sl;
    logic               c_sl;
    logic               msb_cin;
    logic               ovf_d;
    logic               last_d;
    logic [WIDTH-1:0]   sum_d;
    logic [WIDTH-1:0]   final_d;

`ifdef ALU_SAT_EN
    // Signed limit in the direction of the true result: +max when A was
    // non-negative (overflow can only push a positive result past +max).
    function automatic logic signed [WIDTH-1:0] sat_limit(input logic a_msb);
        logic signed [WIDTH-1:0] lim;
        lim = {1'b1, {(WIDTH-1){1'b0}}};
        if (!a_msb) begin
            lim = ~lim;
        end
        return lim;
    endfunction
`endif

    // Slice adder for the current slice plus the assembled/final result.
    always_comb begin
        a_sl    = a_q[int'(idx_q)*CHUNK +: CHUNK];
        b_sl    = b_q[int'(idx_q)*CHUNK +: CHUNK];
        {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
        // Sum bit = a ^ b ^ cin, so the carry into the slice MSB falls out
        // of the MSB bits directly; on the last slice this is the carry
        // into the word MSB.
        msb_cin = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1];
        ovf_d   = msb_cin ^ c_sl;
        last_d  = (idx_q == IDX_W'(NCHUNK - 1));
        sum_d   = sum_q;
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = s_sl;
        final_d = sum_d;
`ifdef ALU_SAT_EN
        if (ovf_d) begin
            final_d = sat_limit(a_q[WIDTH-1]);
        end
`endif
    end

    // Control FSM with registered datapath and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction as A + ~B + 1: invert B, seed carry.
                        a_q     <= A;
                        b_q     <= SUB ? ~B : B;
                        carry_q <= SUB;
                        idx_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    carry_q <= c_sl;
                    if (last_d) begin
                        sum_q       <= final_d;
                        cout_q      <= c_sl;
                        ovf_q       <= ovf_d;
                        zero_q      <= (final_d == '0);
                        neg_q       <= final_d[WIDTH-1];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        sum_q <= sum_d;
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign SUM       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_rca_seq_addsub.sv
// Directed bench for rca_seq_addsub: default 8/4 instance, a 16/1 instance
// for long latency and an 8/8 instance for the single-cycle case.
module tb_rca_seq_addsub;

    logic clk;
    logic rst_n;

    // 8-bit, 4-bit slices
    logic       in_valid, in_ready, out_valid, out_ready, SUB;
    logic [7:0] A, B, SUM;
    logic       cout, ovf, zero, neg;

    // 16-bit, 1-bit slices
    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_SUB;
    logic [15:0] w_A, w_B, w_SUM;
    logic        w_cout, w_ovf, w_zero, w_neg;

    // 8-bit, single slice
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_SUB;
    logic [7:0] s_A, s_B, s_SUM;
    logic       s_cout, s_ovf, s_zero, s_neg;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;

    rca_seq_addsub #(.WIDTH(8), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .SUB(SUB), .out_valid(out_valid), .out_ready(out_ready),
        .SUM(SUM), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    rca_seq_addsub #(.WIDTH(16), .CHUNK(1)) u_wide (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .A(w_A), .B(w_B), .SUB(w_SUB), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .SUM(w_SUM), .cout(w_cout), .ovf(w_ovf), .zero(w_zero), .neg(w_neg)
    );

    rca_seq_addsub #(.WIDTH(8), .CHUNK(8)) u_single (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .A(s_A), .B(s_B), .SUB(s_SUB), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .SUM(s_SUM), .cout(s_cout), .ovf(s_ovf), .zero(s_zero), .neg(s_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one op on the 8/4 instance and wait (bounded) for out_valid.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input string tag);
        A = a; B = b; SUB = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 2);
    endtask

    task automatic chk_res(input string tag, input logic [7:0] s, input logic c,
                           input logic o, input logic z, input logic n);
        chk({tag, "_sum"},  SUM,  s);
        chk({tag, "_cout"}, cout, c);
        chk({tag, "_ovf"},  ovf,  o);
        chk({tag, "_zero"}, zero, z);
        chk({tag, "_neg"},  neg,  n);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ovld_drop"}, out_valid, 0);
        chk({tag, "_rdy_back"},  in_ready,  1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; SUB = 0; A = 0; B = 0;
        w_in_valid = 0; w_out_ready = 0; w_SUB = 0; w_A = 0; w_B = 0;
        s_in_valid = 0; s_out_ready = 0; s_SUB = 0; s_A = 0; s_B = 0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", SUM, 0);
        chk("rst_flags", {cout, ovf, zero, neg}, 0);
        chk("rst_w_in_ready", w_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 0x7F + 0x01: positive overflow
        do_op(8'h7F, 8'h01, 1'b0, "add7f");
`ifdef ALU_SAT_EN
        chk_res("add7f", 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
`else
        chk_res("add7f", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
        chk("add7f_busy_rdy", in_ready, 0);
        drain("add7f");

        // 0x05 - 0x05 = 0, no borrow
        do_op(8'h05, 8'h05, 1'b1, "sub55");
        chk_res("sub55", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        drain("sub55");

        // 0xFF + 0x01 wraps to 0 with carry
        do_op(8'hFF, 8'h01, 1'b0, "addff");
        chk_res("addff", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        drain("addff");

        // 0x80 - 0x01: negative overflow
        do_op(8'h80, 8'h01, 1'b1, "sub80");
`ifdef ALU_SAT_EN
        chk_res("sub80", 8'h80, 1'b1, 1'b1, 1'b0, 1'b1);
`else
        chk_res("sub80", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
        drain("sub80");

        // 0x3C - 0x5A = 0xE2 with borrow (cout=0), negative, no overflow
        do_op(8'h3C, 8'h5A, 1'b1, "sub3c");
        chk_res("sub3c", 8'hE2, 1'b0, 1'b0, 1'b0, 1'b1);
        drain("sub3c");

        // Backpressure: in_valid stays high with a second op waiting
        A = 8'h10; B = 8'h20; SUB = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        A = 8'h01; B = 8'h02;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_lat", lat, 2);
        for (int i = 0; i < 3; i++) begin
            chk("bp_sum_hold", SUM, 8'h30);
            chk("bp_ovld_hold", out_valid, 1);
            chk("bp_rdy_low", in_ready, 0);
            @(posedge clk); #1;
        end
        chk("bp_sum_hold_end", SUM, 8'h30);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_after_hs_ovld", out_valid, 0);
        chk("bp_after_hs_rdy", in_ready, 1);
        chk("bp_idle_sum_kept", SUM, 8'h30);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_accepted", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp2_lat", lat, 2);
        chk_res("bp2", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("bp2");

        // Reset one cycle into BUSY aborts the op
        A = 8'h55; B = 8'h11; SUB = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_ovld", out_valid, 0);
        chk("rstmid_sum", SUM, 0);
        chk("rstmid_rdy", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_not_resumed", out_valid, 0);
        do_op(8'h12, 8'h34, 1'b0, "add12");
        chk_res("add12", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("add12");

        // 16-bit, 1-bit slices: 16-cycle latency
        w_A = 16'h1234; w_B = 16'h4321; w_SUB = 1'b0; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        lat = 0;
        while (!w_out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("wide_lat", lat, 16);
        chk("wide_sum", w_SUM, 16'h5555);
        chk("wide_flags", {w_cout, w_ovf, w_zero, w_neg}, 0);
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        chk("wide_ovld_drop", w_out_valid, 0);

        // Single-slice build: one-cycle latency
        s_A = 8'h20; s_B = 8'h22; s_SUB = 1'b0; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("single_lat", lat, 1);
        chk("single_sum", s_SUM, 8'h42);
        chk("single_flags", {s_cout, s_ovf, s_zero, s_neg}, 0);
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        chk("single_rdy_back", s_in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
